pwm_generator: RTL
==================

# pwm_generator

Single-channel pulse-width modulator clocked by the prescaler tick from `counter_with_strobe`. Each `tick` advances an internal period counter. The output `pwm` is high for `duty` ticks out of every `period` ticks. New period/duty pairs arrive over a one-deep valid/ready port and take effect only on a period boundary, so the output never glitches.

## Interface
- `WIDTH`, 8: width of the period counter, `cfg_period` and `cfg_duty`.
- `IDLE_LEVEL`, 1'b0: level driven on `pwm` while idle and during reset.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `tick` in 1: count enable, one-cycle strobe (prescaler `strobe`); may be held high for full-rate counting.
- `cfg_valid` in 1: a configuration pair is offered.
- `cfg_ready` out 1: the pending slot is empty and can accept the pair.
- `cfg_period` in WIDTH: ticks per PWM cycle. 0 means stop at the next boundary.
- `cfg_duty` in WIDTH: high ticks per cycle. A value ≥ period gives 100 %.
- `pwm` out 1: registered PWM output.
- `period_end` out 1: one-cycle strobe marking the tick that closes a cycle.
- `active` out 1: a non-zero period is running.

## Operation
- **Registers:**
  - `cnt`: WIDTH bits.
  - `cur_period`, `cur_duty`: the running configuration.
  - `pend_period`, `pend_duty`, `pend_valid`: the pending slot.
- **Handshake:**
  - `cfg_ready = !pend_valid`.
  - A transfer happens when `cfg_valid && cfg_ready`; the pair is written to the pending slot and `pend_valid` is set.
  - The payload must be stable while `cfg_valid && !cfg_ready`.
- **IDLE state** (`active`=0):
  - `cnt` is held at 0 and `pwm` = `IDLE_LEVEL`.
  - If `pend_valid` is set and `pend_period`≠0: load `cur_*` from the pending slot, clear `pend_valid`, set `active`=1, `cnt`=0, `pwm`=(0 < duty).
  - If `pend_period`=0: clear `pend_valid` and stay IDLE.
  - `tick` is ignored.
- **RUN state** (`active`=1), on `tick`:
  - If `cnt == cur_period-1`, this is a boundary:
    - Set `cnt`=0 and pulse `period_end`.
    - If `pend_valid`: load `cur_*` from the pending slot and clear `pend_valid`. If the new period is 0, go to IDLE and drive `pwm`=`IDLE_LEVEL`.
  - Otherwise `cnt`=`cnt`+1.
- **RUN state, without `tick`:** all state is held.
- **Output:** `pwm` is registered from the next-state values, `pwm <= (cnt_next < duty_next)`, with an unsigned compare. This gives:
  - duty 0: constant low.
  - duty ≥ period: constant high.
- **Width rules:**
  - `cur_period-1` is computed in WIDTH bits and is never evaluated when the period is 0, so there is no wrap.
  - `cnt` never exceeds `cur_period-1`.
- **Simultaneous events:**
  - A transfer and a boundary in the same cycle: the boundary uses the old pending content (the slot was empty, so there is no load). The new pair waits for the next boundary.
  - `rst` with any other input: reset wins.
- **Reset mid-operation:** the running cycle and any pending pair are discarded; nothing is flushed.

## Timing
- **Reset values:**
  - `pwm`=`IDLE_LEVEL`, `period_end`=0, `active`=0, `cfg_ready`=1.
  - `cnt`=0, `cur_*`=0, `pend_valid`=0.
- **Load from idle:** transfer at edge t; `active` and valid `pwm` appear after edge t+1 (2-cycle latency from `cfg_valid`).
- **Tick to output:** `pwm` and `period_end` update on the same edge that consumes `tick` (1-cycle latency).
- **Reconfiguration while running:** the new values take effect on the edge of the boundary tick. The first `pwm` value of the new cycle already uses the new duty.
- **Ready after a boundary load:** `cfg_ready` returns high the cycle after the boundary load (or the idle load).
- **Continuous tick:** with `tick` held high and period P, `period_end` fires every P cycles.

## Structure
- **Shared header `pwm_defs.vh`:**
  - `PWM_STOP` (period 0 encoding).
  - Default `WIDTH`.
  - The `IDLE_LEVEL` default.
- **Sub-module `pwm_cfg_buffer`:** the one-entry valid/ready holding register for period/duty. It has load/consume inputs and `pend_valid`/`cfg_ready` outputs.
- **Top level:** the top holds the counter, the compare, and the IDLE/RUN bit.
- **Formal:** formal properties are guarded by `` `ifdef FORMAL ``. They include:
  - `period_end` is one-cycle.
  - `cnt < cur_period` while active.
  - The pending slot is never overwritten while `pend_valid`.

## Test plan
- **Idle load:** reset, then offer period=5, duty=2 with `tick` held high → `active` rises 2 cycles after the transfer; `pwm` repeats 1,1,0,0,0; `period_end` pulses every 5 cycles.
- **Prescaled tick:** `tick` every 3rd cycle, period=4, duty=1 → `pwm` high for 3 cycles then low for 9; `period_end` every 12 cycles.
- **Mid-cycle update:** offer period=4, duty=3 at `cnt`=2 of a period=5 cycle → the old cycle completes; the new pattern 1,1,1,0 starts on the boundary; `cfg_ready` low until then; a second offer stalls.
- **Extremes:**
  - duty=0 → `pwm` constant 0.
  - duty=9 with period=6 → constant 1.
  - period=1 → `period_end` on every tick.
  - period=2^WIDTH−1 with `cnt` at max−1 → no wrap.
- **Stop:** offer period=0 while running → at the next boundary `active`=0 and `pwm`=`IDLE_LEVEL`; a later period=3, duty=1 restarts.
- **Reset mid-operation:** assert `rst` at `cnt`=3 with a pair pending → the next cycle shows all outputs at their reset values and `cfg_ready`=1; the pending pair is never applied.

Source files
------------

// File: rtl/pwm_generator_pkg.sv
// Shared constants for the PWM generator: default width, idle level and the
// period encoding that stops the generator.
package pwm_generator_pkg;

    localparam int unsigned PwmDefaultWidth     = 8;
    localparam logic        PwmDefaultIdleLevel = 1'b0;
    // A configured period of zero means "stop at the next boundary".
    localparam int unsigned PwmStop             = 0;

endpackage

// File: rtl/pwm_cfg_buffer.sv
// One-entry valid/ready holding register for a period/duty pair. A pair is
// accepted only while the slot is empty and stays put until consumed.
module pwm_cfg_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    input  logic             consume,
    output logic             cfg_ready,
    output logic             pend_valid,
    output logic [WIDTH-1:0] pend_period,
    output logic [WIDTH-1:0] pend_duty
);

    logic             pend_valid_q;
    logic [WIDTH-1:0] pend_period_q;
    logic [WIDTH-1:0] pend_duty_q;
    logic             load;

    // Load and consume are mutually exclusive: load needs an empty slot,
    // consume needs a full one.
    assign load = cfg_valid && !pend_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q  <= 1'b0;
            pend_period_q <= '0;
            pend_duty_q   <= '0;
        end else if (load) begin
            pend_valid_q  <= 1'b1;
            pend_period_q <= cfg_period;
            pend_duty_q   <= cfg_duty;
        end else if (consume) begin
            pend_valid_q  <= 1'b0;
        end
    end

    assign cfg_ready   = !pend_valid_q;
    assign pend_valid  = pend_valid_q;
    assign pend_period = pend_period_q;
    assign pend_duty   = pend_duty_q;

`ifdef FORMAL
    ap_no_overwrite: assert property (@(posedge clk) disable iff (rst)
        pend_valid_q && !consume |=> pend_valid_q
            && pend_period_q == $past(pend_period_q)
            && pend_duty_q == $past(pend_duty_q));
`endif

endmodule

// File: rtl/pwm_generator.sv
// Single-channel PWM: tick-driven period counter, registered duty compare and
// an IDLE/RUN bit; new settings are applied only on a period boundary.
module pwm_generator
    import pwm_generator_pkg::*;
#(
    parameter int unsigned WIDTH      = PwmDefaultWidth,
    parameter logic        IDLE_LEVEL = PwmDefaultIdleLevel
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic             pwm,
    output logic             period_end,
    output logic             active
);

    localparam logic [WIDTH-1:0] StopPeriod = WIDTH'(PwmStop);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_period_q, cur_period_d;
    logic [WIDTH-1:0] cur_duty_q, cur_duty_d;
    logic             active_q, active_d;
    logic             pwm_q, pwm_d;
    logic             period_end_q, period_end_d;

    logic             consume;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_period;
    logic [WIDTH-1:0] pend_duty;
    logic [WIDTH-1:0] last_cnt;

    pwm_cfg_buffer #(
        .WIDTH (WIDTH)
    ) u_cfg_buffer (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .consume     (consume),
        .cfg_ready   (cfg_ready),
        .pend_valid  (pend_valid),
        .pend_period (pend_period),
        .pend_duty   (pend_duty)
    );

    // Only used while running, where the period is never zero.
    assign last_cnt = cur_period_q - WIDTH'(1);

    always_comb begin
        cnt_d        = cnt_q;
        cur_period_d = cur_period_q;
        cur_duty_d   = cur_duty_q;
        active_d     = active_q;
        period_end_d = 1'b0;
        consume      = 1'b0;

        if (!active_q) begin
            cnt_d = '0;
            if (pend_valid) begin
                consume = 1'b1;
                if (pend_period != StopPeriod) begin
                    active_d     = 1'b1;
                    cur_period_d = pend_period;
                    cur_duty_d   = pend_duty;
                end
            end
        end else if (tick) begin
            if (cnt_q == last_cnt) begin
                cnt_d        = '0;
                period_end_d = 1'b1;
                if (pend_valid) begin
                    consume      = 1'b1;
                    cur_period_d = pend_period;
                    cur_duty_d   = pend_duty;
                    if (pend_period == StopPeriod) begin
                        active_d = 1'b0;
                    end
                end
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end

        // Compare on next-state values so the first cycle of a new setting
        // already reflects the new duty.
        pwm_d = active_d ? (cnt_d < cur_duty_d) : IDLE_LEVEL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            cur_period_q <= '0;
            cur_duty_q   <= '0;
            active_q     <= 1'b0;
            pwm_q        <= IDLE_LEVEL;
            period_end_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            cur_period_q <= cur_period_d;
            cur_duty_q   <= cur_duty_d;
            active_q     <= active_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
        end
    end

    assign pwm        = pwm_q;
    assign period_end = period_end_q;
    assign active     = active_q;

`ifdef FORMAL
    ap_end_from_tick: assert property (@(posedge clk) disable iff (rst)
        period_end |-> $past(tick && active_q));
    ap_cnt_in_range: assert property (@(posedge clk) disable iff (rst)
        active_q |-> cnt_q < cur_period_q);
`endif

endmodule
